// File: rtl/tft_pkg.sv
// tft_pkg: shared TFT timing constants, pixel type and fetch FSM states
package tft_pkg;
  localparam int H_ACT = 640;
  localparam int V_ACT = 480;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int HDAT_BEGIN = 144;
  localparam int VDAT_BEGIN = 35;
  localparam int BURST_LEN = 64;
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;
  typedef enum logic [2:0] {IDLE, WAIT_SPACE, REQ, DATA, DRAIN} fetch_state_t;
endpackage

// File: rtl/tft_pix_fifo.sv
// tft_pix_fifo: first-word-fall-through pixel FIFO with synchronous flush and occupancy output
module tft_pix_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 256
) (
  input  logic                     Clk33M,
  input  logic                     Rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, do_push, do_pop;
  assign empty = (level == '0);
  assign full = (level == LW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = empty ? '0 : mem[rd_ptr];
  // storage array; a flushed write is dropped along with the rest of the old frame
  always_ff @(posedge Clk33M)
    if (do_push && !flush) mem[wr_ptr] <= din;
  // pointers and occupancy; flush empties the FIFO in one cycle
  always_ff @(posedge Clk33M or negedge Rst_n)
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/tft_frame_fetch.sv
// tft_frame_fetch: fetches one frame per refresh over a burst-read port into a FWFT pixel FIFO
module tft_frame_fetch #(
  parameter int ADDR_W = 24,
  parameter int H_ACT = tft_pkg::H_ACT,
  parameter int V_ACT = tft_pkg::V_ACT,
  parameter int BURST_LEN = tft_pkg::BURST_LEN,
  parameter int FIFO_DEPTH = 256
) (
  input  logic                          Clk33M,
  input  logic                          Rst_n,
  input  logic                          TFT_VS,
  input  logic                          wr_en,
  output logic [15:0]                   pix_data,
  input  logic [ADDR_W-1:0]             fb_base,
  output logic                          mem_rd_req,
  output logic [ADDR_W-1:0]             mem_rd_addr,
  output logic [7:0]                    mem_rd_len,
  input  logic                          mem_rd_ack,
  input  logic                          mem_rd_valid,
  input  logic [15:0]                   mem_rd_data,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  import tft_pkg::*;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int TOTAL = H_ACT * V_ACT / BURST_LEN;
  localparam int BUR_W = $clog2(TOTAL + 1);
  fetch_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, rem;
  logic [ADDR_W-1:0] addr, addr_n, rd_addr_n;
  logic [BUR_W-1:0] bursts, bursts_n;
  logic stale, stale_n, vs_r1, vs_r2, frame_start, push, empty;
  assign frame_start = vs_r2 & ~vs_r1;
  assign mem_rd_req = (state == REQ);
  assign mem_rd_len = 8'(BURST_LEN);
  assign rem = CNT_W'(BURST_LEN) - cnt - CNT_W'(mem_rd_valid);
  tft_pix_fifo #(.W($bits(rgb565_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk33M(Clk33M),
    .Rst_n(Rst_n),
    .flush(frame_start),
    .push(push),
    .din(mem_rd_data),
    .pop(wr_en),
    .dout(pix_data),
    .level(fifo_level),
    .empty(empty)
  );
  // vsync edge detector and sticky underflow, cleared at each frame start
  always_ff @(posedge Clk33M or negedge Rst_n)
    if (!Rst_n) begin
      vs_r1 <= 1'b0;
      vs_r2 <= 1'b0;
      underflow <= 1'b0;
    end else begin
      vs_r1 <= TFT_VS;
      vs_r2 <= vs_r1;
      underflow <= frame_start ? 1'b0 : underflow | (wr_en & empty);
    end
  // fetch state, burst bookkeeping and the held request address
  always_ff @(posedge Clk33M or negedge Rst_n)
    if (!Rst_n) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      bursts <= '0;
      stale <= 1'b0;
      mem_rd_addr <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      addr <= addr_n;
      bursts <= bursts_n;
      stale <= stale_n;
      mem_rd_addr <= rd_addr_n;
    end
  // next state; a burst already requested for the old frame is drained, never cancelled
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    addr_n = addr;
    bursts_n = bursts;
    stale_n = 1'b0;
    rd_addr_n = mem_rd_addr;
    push = 1'b0;
    case (state)
      IDLE: if (frame_start) state_n = WAIT_SPACE;
      WAIT_SPACE:
        if (!frame_start) begin
          if (bursts == BUR_W'(TOTAL)) state_n = IDLE;
          else if (fifo_level <= LVL_W'(FIFO_DEPTH - BURST_LEN)) begin
            state_n = REQ;
            rd_addr_n = addr;
          end
        end
      REQ:
        if (mem_rd_ack) begin
          state_n = (stale | frame_start) ? DRAIN : DATA;
          cnt_n = (stale | frame_start) ? CNT_W'(BURST_LEN) : '0;
        end else stale_n = stale | frame_start;
      DATA:
        if (frame_start) begin
          state_n = (rem == '0) ? WAIT_SPACE : DRAIN;
          cnt_n = rem;
        end else if (mem_rd_valid) begin
          push = 1'b1;
          if (cnt == CNT_W'(BURST_LEN - 1)) begin
            state_n = WAIT_SPACE;
            addr_n = addr + ADDR_W'(BURST_LEN);
            bursts_n = bursts + BUR_W'(1);
          end else cnt_n = cnt + CNT_W'(1);
        end
      DRAIN:
        if (mem_rd_valid) begin
          cnt_n = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_n = WAIT_SPACE;
        end
      default: state_n = IDLE;
    endcase
    if (frame_start) begin
      addr_n = fb_base;
      bursts_n = '0;
    end
  end
endmodule

// File: tb/tb_tft_frame_fetch.sv
// tb_tft_frame_fetch: directed scenarios for the frame fetcher with a scaled 16x4 frame
module tb_tft_frame_fetch;
  localparam int H = 16, V = 4, BL = 8, DEPTH = 32, GAP = 24, LW = 6;
  logic Clk33M = 1'b0, Rst_n = 1'b0, TFT_VS = 1'b1, wr_en = 1'b0;
  logic [23:0] fb_base = '0;
  logic [15:0] pix_data;
  logic mem_rd_req;
  logic [23:0] mem_rd_addr;
  logic [7:0] mem_rd_len;
  logic mem_rd_ack = 1'b0, mem_rd_valid = 1'b0;
  logic [15:0] mem_rd_data = '0;
  logic underflow;
  logic [LW-1:0] fifo_level;
  int vectors = 0, errors = 0;
  int ack_delay = 2, wcnt = 0, lat = 0, ackc = -1, bursts = 0;
  bit stall = 1'b0;
  logic [23:0] cur = '0;

  always #15 Clk33M = ~Clk33M;

  tft_frame_fetch #(.ADDR_W(24), .H_ACT(H), .V_ACT(V), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH)) dut (
    .Clk33M(Clk33M), .Rst_n(Rst_n), .TFT_VS(TFT_VS), .wr_en(wr_en), .pix_data(pix_data),
    .fb_base(fb_base), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len),
    .mem_rd_ack(mem_rd_ack), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .underflow(underflow), .fifo_level(fifo_level)
  );

  // memory model: data word equals low 16 bits of its word address
  initial forever begin
    @(negedge Clk33M);
    mem_rd_ack = 1'b0;
    mem_rd_valid = 1'b0;
    if (!Rst_n) begin
      wcnt = 0; lat = 0; ackc = -1;
    end else if (wcnt > 0) begin
      if (lat > 0) lat--;
      else if (!stall) begin
        mem_rd_valid = 1'b1; mem_rd_data = cur[15:0]; cur++; wcnt--;
      end
    end else if (mem_rd_req) begin
      if (ackc < 0) ackc = ack_delay;
      if (ackc == 0) begin
        mem_rd_ack = 1'b1; cur = mem_rd_addr; wcnt = BL; lat = 1; ackc = -1; bursts++;
      end else ackc--;
    end else ackc = -1;
  end

  always @(negedge Clk33M)
    assert (fifo_level <= LW'(DEPTH)) else begin
      errors++;
      $display("FAIL fifo_overflow level=%0d max=%0d", fifo_level, DEPTH);
    end

  initial begin
    #(30 * 30000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic wait_req(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge Clk33M);
      if (mem_rd_req) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_fill(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge Clk33M);
      if (fifo_level != '0) break;
    end
  endtask

  task automatic vs_raise;
    @(negedge Clk33M) TFT_VS = 1'b1;
    @(negedge Clk33M);
  endtask

  task automatic consume(input int lines, input logic [15:0] first);
    logic [15:0] exp;
    exp = first;
    for (int l = 0; l < lines; l++) begin
      for (int x = 0; x < H; x++) begin
        @(negedge Clk33M) wr_en = 1'b1;
        vectors++;
        if (pix_data !== exp) begin
          errors++;
          $display("FAIL pixel x=%0d y=%0d got=%h exp=%h", x, l, pix_data, exp);
        end
        exp++;
      end
      @(negedge Clk33M) wr_en = 1'b0;
      repeat (GAP - 1) @(negedge Clk33M);
    end
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk33M);
    vectors += 5;
    if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", mem_rd_req); end
    if (mem_rd_addr !== 24'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_rd_addr); end
    if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
    if (fifo_level !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    if (pix_data !== 16'h0) begin errors++; $display("FAIL reset_pix got=%h exp=0", pix_data); end
    @(negedge Clk33M) Rst_n = 1'b1;
    repeat (3) @(negedge Clk33M);
  endtask

  task automatic test_full_frame;
    bit ok, seen;
    fb_base = 24'h0;
    bursts = 0;
    @(negedge Clk33M) TFT_VS = 1'b0;
    wait_req(20, ok);
    vectors += 3;
    if (!ok) begin errors++; $display("FAIL frame_first_req got=timeout exp=req"); end
    if (mem_rd_addr !== 24'h0) begin errors++; $display("FAIL frame_first_addr got=%h exp=0", mem_rd_addr); end
    if (mem_rd_len !== 8'(BL)) begin errors++; $display("FAIL frame_len got=%0d exp=%0d", mem_rd_len, BL); end
    vs_raise();
    repeat (100) @(negedge Clk33M);
    vectors++;
    if (fifo_level !== LW'(DEPTH)) begin errors++; $display("FAIL frame_prefill got=%0d exp=%0d", fifo_level, DEPTH); end
    consume(V, 16'h0);
    repeat (2) @(negedge Clk33M);
    vectors += 3;
    if (fifo_level !== '0) begin errors++; $display("FAIL frame_end_level got=%0d exp=0", fifo_level); end
    if (underflow !== 1'b0) begin errors++; $display("FAIL frame_underflow got=%b exp=0", underflow); end
    if (bursts != H * V / BL) begin errors++; $display("FAIL frame_bursts got=%0d exp=%0d", bursts, H * V / BL); end
    seen = 1'b0;
    repeat (60) begin
      @(negedge Clk33M);
      if (mem_rd_req) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin errors++; $display("FAIL frame_req_after_done got=1 exp=0"); end
  endtask

  task automatic test_restart_data;
    bit ok;
    fb_base = 24'h001000;
    @(negedge Clk33M) TFT_VS = 1'b0;
    wait_req(20, ok);
    vs_raise();
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk33M);
      if (wcnt == BL - 4 && lat == 0) break;
    end
    fb_base = 24'h00ABC0;
    TFT_VS = 1'b0;
    wait_req(40, ok);
    vectors += 4;
    if (!ok) begin errors++; $display("FAIL drain_req got=timeout exp=req"); end
    if (wcnt != 0) begin errors++; $display("FAIL drain_inflight got=%0d exp=0", wcnt); end
    if (mem_rd_addr !== 24'h00ABC0) begin errors++; $display("FAIL drain_addr got=%h exp=00abc0", mem_rd_addr); end
    if (fifo_level !== '0) begin errors++; $display("FAIL drain_level got=%0d exp=0", fifo_level); end
    vs_raise();
    wait_fill(30);
    vectors++;
    if (pix_data !== 16'hABC0) begin errors++; $display("FAIL drain_pix0 got=%h exp=abc0", pix_data); end
  endtask

  task automatic test_restart_req;
    bit ok, held;
    int hold;
    repeat (80) @(negedge Clk33M);
    ack_delay = 10;
    fb_base = 24'h002000;
    @(negedge Clk33M) TFT_VS = 1'b0;
    wait_req(20, ok);
    vectors += 2;
    if (!ok) begin errors++; $display("FAIL reqfs_req got=timeout exp=req"); end
    if (mem_rd_addr !== 24'h002000) begin errors++; $display("FAIL reqfs_addr got=%h exp=002000", mem_rd_addr); end
    fb_base = 24'h003000;
    TFT_VS = 1'b1;
    held = 1'b1;
    hold = 0;
    for (int i = 1; i < 30; i++) begin
      @(negedge Clk33M);
      if (i == 2) TFT_VS = 1'b0;
      if (!mem_rd_req) break;
      if (mem_rd_addr !== 24'h002000) held = 1'b0;
      hold++;
    end
    vectors += 2;
    if (held !== 1'b1) begin errors++; $display("FAIL reqfs_addr_stable got=changed exp=002000"); end
    if (hold < 8) begin errors++; $display("FAIL reqfs_hold got=%0d exp>=8", hold); end
    ack_delay = 2;
    wait_req(40, ok);
    vectors += 4;
    if (!ok) begin errors++; $display("FAIL reqfs_next_req got=timeout exp=req"); end
    if (wcnt != 0) begin errors++; $display("FAIL reqfs_inflight got=%0d exp=0", wcnt); end
    if (mem_rd_addr !== 24'h003000) begin errors++; $display("FAIL reqfs_next_addr got=%h exp=003000", mem_rd_addr); end
    if (fifo_level !== '0) begin errors++; $display("FAIL reqfs_level got=%0d exp=0", fifo_level); end
    vs_raise();
    wait_fill(30);
    vectors++;
    if (pix_data !== 16'h3000) begin errors++; $display("FAIL reqfs_pix0 got=%h exp=3000", pix_data); end
  endtask

  task automatic test_underflow;
    repeat (80) @(negedge Clk33M);
    fb_base = 24'h0;
    @(negedge Clk33M) TFT_VS = 1'b0;
    vs_raise();
    repeat (100) @(negedge Clk33M);
    stall = 1'b1;
    consume(2, 16'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk33M) wr_en = 1'b1;
      vectors++;
      if (pix_data !== 16'h0) begin errors++; $display("FAIL empty_pix got=%h exp=0", pix_data); end
    end
    @(negedge Clk33M) wr_en = 1'b0;
    vectors += 2;
    if (fifo_level !== '0) begin errors++; $display("FAIL empty_level got=%0d exp=0", fifo_level); end
    if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set got=%b exp=1", underflow); end
    repeat (50) @(negedge Clk33M);
    stall = 1'b0;
    repeat (20) @(negedge Clk33M);
    vectors++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky got=%b exp=1", underflow); end
    @(negedge Clk33M) TFT_VS = 1'b0;
    repeat (4) @(negedge Clk33M);
    vectors++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear got=%b exp=0", underflow); end
    vs_raise();
  endtask

  task automatic test_async_reset;
    bit ok;
    repeat (60) @(negedge Clk33M);
    fb_base = 24'h004000;
    @(negedge Clk33M) TFT_VS = 1'b0;
    vs_raise();
    @(negedge Clk33M) wr_en = 1'b1;
    @(negedge Clk33M) wr_en = 1'b0;
    vectors++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL arst_pre_underflow got=%b exp=1", underflow); end
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk33M);
      if (wcnt == BL - 3 && lat == 0) break;
    end
    #3 Rst_n = 1'b0;
    #1;
    vectors += 5;
    if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL arst_req got=%b exp=0", mem_rd_req); end
    if (mem_rd_addr !== 24'h0) begin errors++; $display("FAIL arst_addr got=%h exp=0", mem_rd_addr); end
    if (underflow !== 1'b0) begin errors++; $display("FAIL arst_underflow got=%b exp=0", underflow); end
    if (fifo_level !== '0) begin errors++; $display("FAIL arst_level got=%0d exp=0", fifo_level); end
    if (pix_data !== 16'h0) begin errors++; $display("FAIL arst_pix got=%h exp=0", pix_data); end
    repeat (3) @(negedge Clk33M);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk33M);
    fb_base = 24'h005000;
    @(negedge Clk33M) TFT_VS = 1'b0;
    wait_req(20, ok);
    vectors += 2;
    if (!ok) begin errors++; $display("FAIL arst_next_req got=timeout exp=req"); end
    if (mem_rd_addr !== 24'h005000) begin errors++; $display("FAIL arst_next_addr got=%h exp=005000", mem_rd_addr); end
    vs_raise();
    wait_fill(30);
    vectors++;
    if (pix_data !== 16'h5000) begin errors++; $display("FAIL arst_pix0 got=%h exp=5000", pix_data); end
    repeat (80) @(negedge Clk33M);
    vectors++;
    if (fifo_level !== LW'(DEPTH)) begin errors++; $display("FAIL arst_refill got=%0d exp=%0d", fifo_level, DEPTH); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_restart_data();
    test_restart_req();
    test_underflow();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
